aes_enc_ctrl: RTL and testbench



---
 rtl/aes_pkg.sv | 18 +
 rtl/aes_vld_pipe.sv | 31 +++
 rtl/aes_enc_ctrl.sv | 164 ++++++++++++++++
 tb/tb_aes_enc_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 encryption sequencing controller:
// bus widths, the idle address seen by the round stages, and the FSM states.
package aes_pkg;

    localparam int AES_BLK_W  = 128;
    localparam int AES_ADDR_W = 4;

    // Address that matches no round stage; the key bus is ignored.
    localparam logic [AES_ADDR_W-1:0] AES_ADDR_IDLE = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2,
        DRAIN = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/aes_vld_pipe.sv
// In-flight block tracker: a LATENCY-deep valid shift register that runs
// alongside the datapath, which carries no valid bit of its own.
// vout is the last stage, busy is the OR of all stages.
module aes_vld_pipe #(
    parameter int LATENCY = 21
) (
    input  logic clk,
    input  logic rst,
    input  logic vin,
    output logic vout,
    output logic busy
);

    logic [LATENCY-1:0] r_vpipe;

    // Shift the valid bits one stage per clock, new entry at stage 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vpipe <= '0;
        end else begin
            r_vpipe[0] <= vin;
            for (int i = 1; i < LATENCY; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
            end
        end
    end

    assign vout = r_vpipe[LATENCY-1];
    assign busy = |r_vpipe;

endmodule

// File: rtl/aes_enc_ctrl.sv
// Sequencing controller for the pipelined AES-128 encryption datapath.
// Streams round keys onto the rkey/addr broadcast bus, admits plaintext with
// a valid/ready handshake, tracks in-flight blocks and drains the pipeline
// before every key reload so no block sees a mixed key set.
// Optional feature: define AES_ENC_CTRL_CNT_EN to add the blk_cnt output
// (completed-block counter, cleared at the start of each key load).
module aes_enc_ctrl
    import aes_pkg::*;
#(
    parameter int NROUNDS = 10,
    parameter int LATENCY = 21
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_valid,
    output logic                  key_ready,
    input  logic [AES_BLK_W-1:0]  key_in,
    output logic [AES_BLK_W-1:0]  rkey,
    output logic [AES_ADDR_W-1:0] addr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [AES_BLK_W-1:0]  in_data,
    output logic [AES_BLK_W-1:0]  dp_din,
    input  logic [AES_BLK_W-1:0]  dp_dout,
    output logic                  out_valid,
    output logic [AES_BLK_W-1:0]  out_data
`ifdef AES_ENC_CTRL_CNT_EN
    ,
    output logic [31:0]           blk_cnt
`endif
);

    localparam int CNT_W = $clog2(NROUNDS + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NROUNDS);

    ctrl_state_t             r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_key_ready;
    logic [AES_BLK_W-1:0]    r_rkey;
    logic [AES_ADDR_W-1:0]   r_addr;
    logic [AES_BLK_W-1:0]    r_dp_din;
    logic                    r_out_valid;

    logic w_key_fire;
    logic w_in_ready;
    logic w_in_fire;
    logic w_vout;
    logic w_busy;

    assign w_key_fire = key_valid & r_key_ready;
    // A pending key reload takes priority over new plaintext.
    assign w_in_ready = (r_state == READY) & ~key_valid;
    assign w_in_fire  = in_valid & w_in_ready;

    aes_vld_pipe #(
        .LATENCY (LATENCY)
    ) u_vld_pipe (
        .clk  (clk),
        .rst  (rst),
        .vin  (w_in_fire),
        .vout (w_vout),
        .busy (w_busy)
    );

    // Key-load FSM: sequences beats onto the broadcast bus and gates data.
    // key_ready is registered from the next state so it stays low in reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_key_ready <= 1'b0;
            r_rkey      <= '0;
            r_addr      <= AES_ADDR_IDLE;
        end else begin
            r_addr <= AES_ADDR_IDLE;
            case (r_state)
                IDLE: begin
                    r_key_ready <= 1'b1;
                    if (w_key_fire) begin
                        r_addr  <= '0;
                        r_rkey  <= key_in;
                        r_cnt   <= CNT_W'(1);
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_key_ready <= 1'b1;
                    if (w_key_fire) begin
                        r_addr <= AES_ADDR_W'(r_cnt);
                        r_rkey <= key_in;
                        if (r_cnt == LAST_BEAT) begin
                            r_state     <= READY;
                            r_key_ready <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                READY: begin
                    r_key_ready <= 1'b0;
                    if (key_valid) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    r_key_ready <= 1'b0;
                    if (!w_busy) begin
                        r_state     <= LOAD;
                        r_cnt       <= '0;
                        r_key_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_cnt       <= '0;
                    r_key_ready <= 1'b0;
                end
            endcase
        end
    end

    // Plaintext register to the datapath and aligned output-valid flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dp_din    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_in_fire) begin
                r_dp_din <= in_data;
            end
            r_out_valid <= w_vout;
        end
    end

`ifdef AES_ENC_CTRL_CNT_EN
    logic [31:0] r_blk_cnt;
    logic        w_load_start;

    assign w_load_start = ((r_state == IDLE) & w_key_fire) |
                          ((r_state == DRAIN) & ~w_busy);

    // Completed-block counter, restarted whenever a new key set begins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_blk_cnt <= 32'd0;
        end else if (w_load_start) begin
            r_blk_cnt <= 32'd0;
        end else if (r_out_valid) begin
            r_blk_cnt <= r_blk_cnt + 32'd1;
        end
    end

    assign blk_cnt = r_blk_cnt;
`endif

    assign key_ready = r_key_ready;
    assign rkey      = r_rkey;
    assign addr      = r_addr;
    assign in_ready  = w_in_ready;
    assign dp_din    = r_dp_din;
    assign out_valid = r_out_valid;
    assign out_data  = dp_dout;

endmodule

// File: tb/tb_aes_enc_ctrl.sv
// Self-checking bench for aes_enc_ctrl with a model datapath of fixed latency.
// Expected ciphertexts are queued at acceptance and checked by a monitor.
module tb_aes_enc_ctrl;
    import aes_pkg::*;

    localparam int NR  = 10;
    localparam int LAT = 21;
    localparam logic [127:0] XMASK = 128'h5A5A_5A5A_0F0F_0F0F_A5A5_A5A5_F0F0_F0F0;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key_in;
    logic [127:0] rkey;
    logic [3:0]   addr;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] dp_din;
    logic [127:0] dp_dout;
    logic         out_valid;
    logic [127:0] out_data;
`ifdef AES_ENC_CTRL_CNT_EN
    logic [31:0]  blk_cnt;
`endif

    aes_enc_ctrl #(.NROUNDS(NR), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_in    (key_in),
        .rkey      (rkey),
        .addr      (addr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .dp_din    (dp_din),
        .dp_dout   (dp_dout),
        .out_valid (out_valid),
        .out_data  (out_data)
`ifdef AES_ENC_CTRL_CNT_EN
        ,
        .blk_cnt   (blk_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Model datapath: LAT register stages then a fixed XOR as the "cipher".
    logic [127:0] dpq [LAT];
    always @(posedge clk) begin
        dpq[0] <= dp_din;
        for (int i = 1; i < LAT; i++) dpq[i] <= dpq[i-1];
    end
    assign dp_dout = dpq[LAT-1] ^ XMASK;

    typedef struct {
        logic [127:0] d;
        int           c;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Monitor: every presented ciphertext must match the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && out_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_out", 128'(out_valid), 128'(0));
            end else begin
                mon_e = sbq.pop_front();
                chk("out_data", out_data, mon_e.d);
                chk("out_latency_cycle", 128'(cyc), 128'(mon_e.c));
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_key_ready"}, 128'(key_ready), 128'(0));
        chk({tag, "_addr"},      128'(addr),      128'(4'hF));
        chk({tag, "_rkey"},      rkey,            128'(0));
        chk({tag, "_in_ready"},  128'(in_ready),  128'(0));
        chk({tag, "_dp_din"},    dp_din,          128'(0));
        chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
    endtask

    // Offer key beats 0..nbeats-1 from posedge+1; optional 3-cycle gap after gap_after.
    task automatic load_keys(input int gap_after, input int nbeats);
        int t;
        for (int b = 0; b < nbeats; b++) begin
            key_valid = 1'b1;
            key_in    = {16{8'(b)}};
            t = 0;
            while (key_ready !== 1'b1 && t < 100) begin
                @(posedge clk); #1; t++;
            end
            if (key_ready !== 1'b1) begin
                chk("key_ready_timeout", 128'(key_ready), 128'(1));
                key_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            chk("beat_addr", 128'(addr), 128'(b));
            chk("beat_rkey", rkey, {16{8'(b)}});
            if (b == gap_after) begin
                key_valid = 1'b0;
                for (int g = 0; g < 3; g++) begin
                    @(posedge clk); #1;
                    chk("gap_addr_idle", 128'(addr), 128'(4'hF));
                end
            end
        end
        key_valid = 1'b0;
        #1;
        if (nbeats == NR + 1) begin
            chk("in_ready_after_load", 128'(in_ready), 128'(1));
            chk("key_ready_after_load", 128'(key_ready), 128'(0));
            @(posedge clk); #1;
            chk("addr_idle_after_load", 128'(addr), 128'(4'hF));
        end
    endtask

    // Offer n back-to-back blocks from posedge+1; queue expected results.
    task automatic send_blocks(input int n, input int base);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = {4{32'hC0DE_0000 + 32'(base + i)}};
            #1;
            chk("in_ready_block", 128'(in_ready), 128'(1));
            if (in_ready === 1'b1) begin
                e.d = in_data ^ XMASK;
                e.c = cyc + 1 + LAT;
                sbq.push_back(e);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int t;
        rst       = 1'b0;
        key_valid = 1'b0;
        key_in    = '0;
        in_valid  = 1'b0;
        in_data   = '0;

        repeat (3) @(posedge clk);
        #2;
        check_reset_vals("reset");
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("key_ready_idle", 128'(key_ready), 128'(1));
        chk("in_ready_idle", 128'(in_ready), 128'(0));

        // Full back-to-back key load.
        load_keys(-1, NR + 1);

        // Eight consecutive blocks.
        send_blocks(8, 0);
        repeat (LAT + 4) @(posedge clk);
        #1;
        chk("sb_empty_after_8", 128'(sbq.size()), 128'(0));

        // Reload with five blocks in flight.
        send_blocks(5, 16);
        key_valid = 1'b1;
        key_in    = {16{8'h00}};
        in_valid  = 1'b1;
        #1;
        chk("in_ready_drop_on_reload", 128'(in_ready), 128'(0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("key_ready_during_drain", 128'(key_ready), 128'(0));
        t = 0;
        while (key_ready !== 1'b1 && t < 100) begin
            @(posedge clk); #1; t++;
        end
        chk("drain_complete_before_load", 128'(sbq.size()), 128'(0));
        chk("drain_cycles_bounded", 128'(t < 100), 128'(1));
        #1;
        chk("no_out_valid_in_load", 128'(out_valid), 128'(0));

        // Key load with a gap after beat 4.
        load_keys(4, NR + 1);

        // Async reset mid-load at beat 6.
        load_keys(-1, 6);
        key_valid = 1'b1;
        key_in    = {16{8'h06}};
        #2;
        rst = 1'b0;
        #1;
        check_reset_vals("midload_reset");
        key_valid = 1'b0;
        in_valid  = 1'b1;
        in_data   = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("in_ready_blocked_after_reset", 128'(in_ready), 128'(0));
        end
        in_valid = 1'b0;
        load_keys(-1, NR + 1);

`ifdef AES_ENC_CTRL_CNT_EN
        send_blocks(3, 32);
        repeat (LAT + 4) @(posedge clk);
        #1;
        chk("blk_cnt_three", 128'(blk_cnt), 128'(3));
        key_valid = 1'b1;
        key_in    = {16{8'h00}};
        t = 0;
        while (key_ready !== 1'b1 && t < 100) begin
            @(posedge clk); #1; t++;
        end
        chk("blk_cnt_cleared_on_reload", 128'(blk_cnt), 128'(0));
        load_keys(-1, NR + 1);
`endif

        repeat (LAT + 4) @(posedge clk);
        #1;
        chk("sb_empty_final", 128'(sbq.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
